// File: rtl/decode_dispatch_controller_pkg.sv
// decode_dispatch_pkg: shared states, opcode constants and instruction field offsets
// Instruction layout, MSB to LSB: flag, opcode, rd, rs1, rs2, pc, imm.
package decode_dispatch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  localparam int OPC_ADD  = 0;
  localparam int OPC_MULT = 1;
  localparam int OPC_DIV  = 2;
  localparam int OPC_COMP = 3;
  function automatic int instr_w(input int f, input int o, input int a, input int p, input int d);
    return f + o + 3 * a + p + d;
  endfunction
  function automatic int off_pc(input int d);
    return d;
  endfunction
  function automatic int off_rs2(input int p, input int d);
    return p + d;
  endfunction
  function automatic int off_rs1(input int a, input int p, input int d);
    return a + p + d;
  endfunction
  function automatic int off_rd(input int a, input int p, input int d);
    return 2 * a + p + d;
  endfunction
  function automatic int off_opc(input int a, input int p, input int d);
    return 3 * a + p + d;
  endfunction
  function automatic int off_flag(input int o, input int a, input int p, input int d);
    return o + 3 * a + p + d;
  endfunction
endpackage

// File: rtl/decode_dispatch_controller_if.sv
// decode_dispatch_controller_if: CPU-side request/response plus execution-unit handshake bus
// Modports:
//   master - the dispatch controller (drives busy/done/status and unit_* issue fields)
//   slave  - the environment (CPU fetch logic and execution units)
interface decode_dispatch_controller_if #(
  parameter int FLAG_W    = 2,
  parameter int OPC_W     = 5,
  parameter int ADDR_W    = 5,
  parameter int PC_W      = 5,
  parameter int DATA_W    = 32,
  parameter int NUM_UNITS = 4
) ();
  localparam int INSTR_W = decode_dispatch_pkg::instr_w(FLAG_W, OPC_W, ADDR_W, PC_W, DATA_W);
  logic                      start;
  logic [INSTR_W-1:0]        instruction;
  logic                      busy;
  logic                      done;
  logic                      illegal;
  logic                      timeout;
  logic                      fetch_stage_enable;
  logic [PC_W-1:0]           next_pc_to_cpu;
  logic [NUM_UNITS-1:0]      unit_start;
  logic [FLAG_W-1:0]         unit_operation_type;
  logic [PC_W-1:0]           unit_pc;
  logic [ADDR_W-1:0]         unit_source_1_address;
  logic [ADDR_W-1:0]         unit_source_2_address;
  logic [ADDR_W-1:0]         unit_destination_address;
  logic [DATA_W-1:0]         unit_source_immediate_value;
  logic [NUM_UNITS-1:0]      unit_busy;
  logic [NUM_UNITS-1:0]      unit_done;
  logic [NUM_UNITS*PC_W-1:0] unit_next_pc;
  modport master (
    input  start, instruction, unit_busy, unit_done, unit_next_pc,
    output busy, done, illegal, timeout, fetch_stage_enable, next_pc_to_cpu, unit_start,
           unit_operation_type, unit_pc, unit_source_1_address, unit_source_2_address,
           unit_destination_address, unit_source_immediate_value
  );
  modport slave (
    output start, instruction, unit_busy, unit_done, unit_next_pc,
    input  busy, done, illegal, timeout, fetch_stage_enable, next_pc_to_cpu, unit_start,
           unit_operation_type, unit_pc, unit_source_1_address, unit_source_2_address,
           unit_destination_address, unit_source_immediate_value
  );
endinterface

// File: rtl/decode_dispatch_controller_instruction_field_decoder.sv
// instruction_field_decoder: combinational split of an instruction word into its fields
// Ports: instr_i (whole word) -> flag_o, opc_o, rd_o, rs1_o, rs2_o, pc_o, imm_o,
//        legal_o (opcode maps to one of the NUM_UNITS execution units)
module instruction_field_decoder import decode_dispatch_pkg::*; #(
  parameter int FLAG_W    = 2,
  parameter int OPC_W     = 5,
  parameter int ADDR_W    = 5,
  parameter int PC_W      = 5,
  parameter int DATA_W    = 32,
  parameter int NUM_UNITS = 4,
  localparam int INSTR_W  = instr_w(FLAG_W, OPC_W, ADDR_W, PC_W, DATA_W)
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [FLAG_W-1:0]  flag_o,
  output logic [OPC_W-1:0]   opc_o,
  output logic [ADDR_W-1:0]  rd_o,
  output logic [ADDR_W-1:0]  rs1_o,
  output logic [ADDR_W-1:0]  rs2_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic               legal_o
);
  assign imm_o   = instr_i[0 +: DATA_W];
  assign pc_o    = instr_i[off_pc(DATA_W) +: PC_W];
  assign rs2_o   = instr_i[off_rs2(PC_W, DATA_W) +: ADDR_W];
  assign rs1_o   = instr_i[off_rs1(ADDR_W, PC_W, DATA_W) +: ADDR_W];
  assign rd_o    = instr_i[off_rd(ADDR_W, PC_W, DATA_W) +: ADDR_W];
  assign opc_o   = instr_i[off_opc(ADDR_W, PC_W, DATA_W) +: OPC_W];
  assign flag_o  = instr_i[off_flag(OPC_W, ADDR_W, PC_W, DATA_W) +: FLAG_W];
  assign legal_o = int'(opc_o) < NUM_UNITS;
endmodule

// File: rtl/decode_dispatch_controller.sv
// decode_dispatch_controller: decodes one instruction per start and dispatches it to an execution unit
// Ports: clk, rst_n (async active-low), bus_if (decode_dispatch_controller_if.master):
//   CPU side  - start, instruction in; busy, done, illegal, timeout, fetch_stage_enable, next_pc_to_cpu out
//   unit side - unit_start (one-hot) and broadcast fields out; unit_busy, unit_done, unit_next_pc in
// Optional feature: define DECODE_DISPATCH_TIMEOUT_EN to build a watchdog that aborts an
// instruction after TIMEOUT_CYCLES cycles in ISSUE/WAIT; otherwise timeout is tied low.
module decode_dispatch_controller import decode_dispatch_pkg::*; #(
  parameter int FLAG_W         = 2,
  parameter int OPC_W          = 5,
  parameter int ADDR_W         = 5,
  parameter int PC_W           = 5,
  parameter int DATA_W         = 32,
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  decode_dispatch_controller_if.master bus_if
);
  state_e               state_q;
  logic [OPC_W-1:0]     sel_q;
  logic [FLAG_W-1:0]    flag_q;
  logic [ADDR_W-1:0]    rd_q, rs1_q, rs2_q;
  logic [PC_W-1:0]      pc_q;
  logic [DATA_W-1:0]    imm_q;
  logic                 busy_q, done_q, illegal_q;
  logic [PC_W-1:0]      next_pc_q;
  logic [NUM_UNITS-1:0] unit_start_q;
  logic [FLAG_W-1:0]    dec_flag;
  logic [OPC_W-1:0]     dec_opc;
  logic [ADDR_W-1:0]    dec_rd, dec_rs1, dec_rs2;
  logic [PC_W-1:0]      dec_pc;
  logic [DATA_W-1:0]    dec_imm;
  logic                 dec_legal;
  logic [NUM_UNITS-1:0] sel_oh;
  logic                 sel_busy, sel_done, finish;
  logic [PC_W-1:0]      sel_pc;
  instruction_field_decoder #(
    .FLAG_W(FLAG_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS)
  ) u_dec (
    .instr_i(bus_if.instruction), .flag_o(dec_flag), .opc_o(dec_opc), .rd_o(dec_rd),
    .rs1_o(dec_rs1), .rs2_o(dec_rs2), .pc_o(dec_pc), .imm_o(dec_imm), .legal_o(dec_legal)
  );
  // Selection mask makes every unselected unit's handshake invisible to the FSM.
  assign sel_oh   = NUM_UNITS'(1) << sel_q;
  assign sel_busy = |(bus_if.unit_busy & sel_oh);
  assign sel_done = |(bus_if.unit_done & sel_oh);
  assign finish   = sel_done & ~sel_busy;
  always_comb begin
    sel_pc = '0;
    for (int k = 0; k < NUM_UNITS; k++) sel_pc |= sel_oh[k] ? bus_if.unit_next_pc[k*PC_W +: PC_W] : '0;
  end
`ifdef DECODE_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;
  assign cnt_d          = cnt_q + CNT_W'(1);
  assign bus_if.timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus_if.timeout     = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      flag_q       <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      next_pc_q    <= '0;
      unit_start_q <= '0;
`ifdef DECODE_DISPATCH_TIMEOUT_EN
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DECODE_DISPATCH_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE:
          if (bus_if.start) begin
            flag_q <= dec_flag;
            rd_q   <= dec_rd;
            rs1_q  <= dec_rs1;
            rs2_q  <= dec_rs2;
            pc_q   <= dec_pc;
            imm_q  <= dec_imm;
            sel_q  <= dec_opc;
            if (dec_legal) begin
              state_q      <= S_ISSUE;
              busy_q       <= 1'b1;
              unit_start_q <= NUM_UNITS'(1) << dec_opc;
`ifdef DECODE_DISPATCH_TIMEOUT_EN
              cnt_q        <= '0;
`endif
            end else begin
              // Unmapped opcode completes immediately without touching any unit.
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              next_pc_q <= dec_pc + PC_W'(1);
            end
          end
        default:
          // ISSUE and WAIT share completion; ISSUE also accepts a same-cycle single-cycle unit.
          if (finish) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            unit_start_q <= '0;
            done_q       <= 1'b1;
            next_pc_q    <= sel_pc;
          end else begin
            if (sel_busy) begin
              state_q      <= S_WAIT;
              unit_start_q <= '0;
            end
`ifdef DECODE_DISPATCH_TIMEOUT_EN
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              unit_start_q <= '0;
              done_q       <= 1'b1;
              timeout_q    <= 1'b1;
              next_pc_q    <= pc_q + PC_W'(1);
            end
`endif
          end
      endcase
    end
  assign bus_if.busy                        = busy_q;
  assign bus_if.done                        = done_q;
  assign bus_if.fetch_stage_enable          = done_q;
  assign bus_if.illegal                     = illegal_q;
  assign bus_if.next_pc_to_cpu              = next_pc_q;
  assign bus_if.unit_start                  = unit_start_q;
  assign bus_if.unit_operation_type         = flag_q;
  assign bus_if.unit_pc                     = pc_q;
  assign bus_if.unit_source_1_address       = rs1_q;
  assign bus_if.unit_source_2_address       = rs2_q;
  assign bus_if.unit_destination_address    = rd_q;
  assign bus_if.unit_source_immediate_value = imm_q;
endmodule

// File: tb/tb_decode_dispatch_controller.sv
// tb_decode_dispatch_controller: directed self-checking bench for decode_dispatch_controller
module tb_decode_dispatch_controller;
  import decode_dispatch_pkg::*;
`ifdef DECODE_DISPATCH_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [8:0] st;
  logic [53:0] bc;
  always #5 clk = ~clk;
  decode_dispatch_controller_if bus_if ();
  decode_dispatch_controller #(.NUM_UNITS(4), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus_if));
  // status: {busy, done, fetch_stage_enable, illegal, timeout, unit_start[3:0]}
  assign st = {bus_if.busy, bus_if.done, bus_if.fetch_stage_enable, bus_if.illegal, bus_if.timeout, bus_if.unit_start};
  assign bc = {bus_if.unit_operation_type, bus_if.unit_destination_address, bus_if.unit_source_1_address,
               bus_if.unit_source_2_address, bus_if.unit_pc, bus_if.unit_source_immediate_value};
  function automatic logic [58:0] mk(input logic [1:0] f, input logic [4:0] o, rd, r1, r2, pc, input logic [31:0] imm);
    return {f, o, rd, r1, r2, pc, imm};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    bus_if.start = 1'b0;
    bus_if.instruction = '0;
    bus_if.unit_busy = '0;
    bus_if.unit_done = '0;
    bus_if.unit_next_pc = '0;
    #1;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL reset_status got=%b exp=%b", st, 9'b0); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd0) begin failures++; $display("FAIL reset_next_pc got=%0d exp=0", bus_if.next_pc_to_cpu); end
    checks++; if (bc !== 54'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", bc); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_add;
    bus_if.instruction = mk(2'd2, 5'(OPC_ADD), 5'd3, 5'd1, 5'd2, 5'd5, 32'h10);
    bus_if.unit_next_pc = {5'd9, 5'd9, 5'd9, 5'd6};
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    checks++; if (st !== 9'b1_0_0_0_0_0001) begin failures++; $display("FAIL add_issue1 got=%b exp=%b", st, 9'b1_0_0_0_0_0001); end
    checks++; if (bc !== {2'd2, 5'd3, 5'd1, 5'd2, 5'd5, 32'h10}) begin failures++; $display("FAIL add_fields got=%h exp=%h", bc, {2'd2, 5'd3, 5'd1, 5'd2, 5'd5, 32'h10}); end
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0001) begin failures++; $display("FAIL add_issue2 got=%b exp=%b", st, 9'b1_0_0_0_0_0001); end
    bus_if.unit_busy = 4'b0001;
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0000) begin failures++; $display("FAIL add_wait got=%b exp=%b", st, 9'b1_0_0_0_0_0000); end
    tick;
    tick;
    bus_if.unit_busy = 4'b0000;
    bus_if.unit_done = 4'b0001;
    tick;
    checks++; if (st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL add_done got=%b exp=%b", st, 9'b0_1_1_0_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd6) begin failures++; $display("FAIL add_next_pc got=%0d exp=6", bus_if.next_pc_to_cpu); end
    bus_if.unit_done = 4'b0000;
    tick;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL add_idle got=%b exp=%b", st, 9'b0); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd6) begin failures++; $display("FAIL add_pc_hold got=%0d exp=6", bus_if.next_pc_to_cpu); end
  endtask
  task automatic test_back_to_back;
    bus_if.unit_next_pc = {5'd7, 5'd11, 5'd12, 5'd13};
    bus_if.instruction = mk(2'd1, 5'(OPC_DIV), 5'd4, 5'd5, 5'd6, 5'd10, 32'h55);
    bus_if.start = 1'b1;
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0100) begin failures++; $display("FAIL multi_div_issue got=%b exp=%b", st, 9'b1_0_0_0_0_0100); end
    bus_if.unit_done = 4'b0011;
    bus_if.instruction = mk(2'd0, 5'(OPC_COMP), 5'd7, 5'd7, 5'd7, 5'd30, 32'h1);
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0100) begin failures++; $display("FAIL multi_stray_ignored got=%b exp=%b", st, 9'b1_0_0_0_0_0100); end
    checks++; if (bus_if.unit_pc !== 5'd10) begin failures++; $display("FAIL multi_fields_stable got=%0d exp=10", bus_if.unit_pc); end
    bus_if.unit_done = 4'b0100;
    bus_if.instruction = mk(2'd3, 5'(OPC_MULT), 5'd8, 5'd9, 5'd10, 5'd20, 32'h77);
    tick;
    checks++; if (st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL multi_div_done got=%b exp=%b", st, 9'b0_1_1_0_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd11) begin failures++; $display("FAIL multi_div_pc got=%0d exp=11", bus_if.next_pc_to_cpu); end
    bus_if.unit_done = 4'b0000;
    tick;
    bus_if.start = 1'b0;
    checks++; if (st !== 9'b1_0_0_0_0_0010) begin failures++; $display("FAIL multi_mult_issue got=%b exp=%b", st, 9'b1_0_0_0_0_0010); end
    checks++; if (bus_if.unit_pc !== 5'd20) begin failures++; $display("FAIL multi_mult_fields got=%0d exp=20", bus_if.unit_pc); end
    bus_if.unit_busy = 4'b0010;
    bus_if.unit_done = 4'b0101;
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0000) begin failures++; $display("FAIL multi_mult_wait got=%b exp=%b", st, 9'b1_0_0_0_0_0000); end
    bus_if.unit_busy = 4'b0000;
    bus_if.unit_done = 4'b0010;
    tick;
    checks++; if (st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL multi_mult_done got=%b exp=%b", st, 9'b0_1_1_0_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd12) begin failures++; $display("FAIL multi_mult_pc got=%0d exp=12", bus_if.next_pc_to_cpu); end
    bus_if.unit_done = 4'b0000;
    tick;
  endtask
  task automatic test_illegal;
    bus_if.instruction = mk(2'd1, 5'd9, 5'd4, 5'd5, 5'd6, 5'd31, 32'hDEAD_BEEF);
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    checks++; if (st !== 9'b0_1_1_1_0_0000) begin failures++; $display("FAIL illegal_done got=%b exp=%b", st, 9'b0_1_1_1_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd0) begin failures++; $display("FAIL illegal_pc_wrap got=%0d exp=0", bus_if.next_pc_to_cpu); end
    tick;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL illegal_pulse got=%b exp=%b", st, 9'b0); end
  endtask
  task automatic test_single_cycle;
    bus_if.instruction = mk(2'd0, 5'(OPC_COMP), 5'd1, 5'd1, 5'd1, 5'd4, 32'h0);
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    checks++; if (st !== 9'b1_0_0_0_0_1000) begin failures++; $display("FAIL single_issue got=%b exp=%b", st, 9'b1_0_0_0_0_1000); end
    bus_if.unit_done = 4'b1000;
    tick;
    checks++; if (st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL single_done got=%b exp=%b", st, 9'b0_1_1_0_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd7) begin failures++; $display("FAIL single_pc got=%0d exp=7", bus_if.next_pc_to_cpu); end
    bus_if.unit_done = 4'b0000;
    tick;
  endtask
  task automatic test_reset_mid;
    bus_if.instruction = mk(2'd2, 5'(OPC_ADD), 5'd2, 5'd3, 5'd4, 5'd1, 32'hABCD);
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    bus_if.unit_busy = 4'b0001;
    tick;
    checks++; if (st !== 9'b1_0_0_0_0_0000) begin failures++; $display("FAIL rst_mid_wait got=%b exp=%b", st, 9'b1_0_0_0_0_0000); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL rst_mid_status got=%b exp=%b", st, 9'b0); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd0) begin failures++; $display("FAIL rst_mid_pc got=%0d exp=0", bus_if.next_pc_to_cpu); end
    checks++; if (bc !== 54'd0) begin failures++; $display("FAIL rst_mid_fields got=%h exp=0", bc); end
    bus_if.unit_busy = 4'b0000;
    bus_if.unit_done = 4'b0001;
    tick;
    tick;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=%b", st, 9'b0); end
    bus_if.unit_done = 4'b0000;
    rst_n = 1'b1;
    tick;
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    checks++; if (st !== 9'b1_0_0_0_0_0001) begin failures++; $display("FAIL rst_mid_restart got=%b exp=%b", st, 9'b1_0_0_0_0_0001); end
    bus_if.unit_done = 4'b0001;
    tick;
    checks++; if (bus_if.next_pc_to_cpu !== 5'd13 || st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL rst_mid_restart_done pc=%0d st=%b exp pc=13 st=%b", bus_if.next_pc_to_cpu, st, 9'b0_1_1_0_0_0000); end
    bus_if.unit_done = 4'b0000;
    tick;
  endtask
  task automatic test_timeout;
    bus_if.instruction = mk(2'd1, 5'(OPC_DIV), 5'd1, 5'd2, 5'd3, 5'd8, 32'h9);
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    bus_if.unit_busy = 4'b0100;
    checks++; if (st !== 9'b1_0_0_0_0_0100) begin failures++; $display("FAIL to_issue got=%b exp=%b", st, 9'b1_0_0_0_0_0100); end
`ifdef DECODE_DISPATCH_TIMEOUT_EN
    repeat (7) tick;
    checks++; if (st !== 9'b1_0_0_0_0_0000) begin failures++; $display("FAIL to_still_busy got=%b exp=%b", st, 9'b1_0_0_0_0_0000); end
    tick;
    checks++; if (st !== 9'b0_1_1_0_1_0000) begin failures++; $display("FAIL to_done got=%b exp=%b", st, 9'b0_1_1_0_1_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd9) begin failures++; $display("FAIL to_pc got=%0d exp=9", bus_if.next_pc_to_cpu); end
    tick;
    checks++; if (st !== 9'b0) begin failures++; $display("FAIL to_idle got=%b exp=%b", st, 9'b0); end
    bus_if.unit_busy = 4'b0000;
`else
    repeat (20) tick;
    checks++; if (st !== 9'b1_0_0_0_0_0000) begin failures++; $display("FAIL no_to_wait got=%b exp=%b", st, 9'b1_0_0_0_0_0000); end
    bus_if.unit_busy = 4'b0000;
    bus_if.unit_done = 4'b0100;
    tick;
    checks++; if (st !== 9'b0_1_1_0_0_0000) begin failures++; $display("FAIL no_to_done got=%b exp=%b", st, 9'b0_1_1_0_0_0000); end
    checks++; if (bus_if.next_pc_to_cpu !== 5'd11) begin failures++; $display("FAIL no_to_pc got=%0d exp=11", bus_if.next_pc_to_cpu); end
    bus_if.unit_done = 4'b0000;
`endif
    tick;
  endtask
  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_illegal;
    test_single_cycle;
    test_reset_mid;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
